// File: rtl/toy_excep_seq.sv
// Exception sequencer: picks one exception by fixed priority and walks flush, SRR0/SRR1/MSR writes, PC redirect and ack.
// Optional RFI sequence enabled by defining TOY_EXCEP_RFI_EN.
module toy_excep_seq #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE     = '0,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqFetch,
  input  logic                  reqUndef,
  input  logic                  reqPriv,
  input  logic                  reqTrap,
  input  logic                  reqSc,
  input  logic                  reqData,
  input  logic                  reqExt,
  input  logic [ADDR_WIDTH-1:0] excepPC,
  input  logic [31:0]           msrIn,
  output logic                  flush,
  output logic                  stall,
  output logic                  sprWrEn,
  output logic [1:0]            sprWrSel,
  output logic [31:0]           sprWrData,
  output logic                  pcRedirect,
  output logic [ADDR_WIDTH-1:0] pcVector,
  output logic [3:0]            excepCode,
  input  logic                  ackIn,
  output logic                  busy
`ifdef TOY_EXCEP_RFI_EN
  ,
  input  logic                  rfiReq,
  input  logic [ADDR_WIDTH-1:0] srr0In,
  input  logic [31:0]           srr1In
`endif
);

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_ISI  = 4'd1;
  localparam logic [3:0] CODE_ILL  = 4'd2;
  localparam logic [3:0] CODE_PRIV = 4'd3;
  localparam logic [3:0] CODE_TRAP = 4'd4;
  localparam logic [3:0] CODE_SC   = 4'd5;
  localparam logic [3:0] CODE_DSI  = 4'd6;
  localparam logic [3:0] CODE_EXT  = 4'd7;

  localparam logic [1:0] SEL_SRR0 = 2'd0;
  localparam logic [1:0] SEL_SRR1 = 2'd1;
  localparam logic [1:0] SEL_MSR  = 2'd2;

  localparam logic [2:0]  FLUSH_LAST   = 3'(FLUSH_CYCLES - 1);
  localparam logic [31:0] SRR1_CLR     = 32'h000F_0000;
  localparam logic [31:0] MSR_CLR      = 32'h0000_C030;

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    SRR0,
    SRR1,
    MSR_WR,
    REDIR,
`ifdef TOY_EXCEP_RFI_EN
    RFI_MSR,
    RFI_REDIR,
`endif
    WAIT_ACK
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [2:0]            cnt;
  logic [2:0]            cntNext;
  logic [3:0]            codeLat;
  logic [ADDR_WIDTH-1:0] pcLat;
  logic [31:0]           msrLat;
  logic [3:0]            reqCode;
  logic                  take;
  logic [31:0]           srr1Data;
  logic [11:0]           vecOffset;

  // Fixed priority; external interrupt only counts while MSR[EE] is set.
  always_comb begin
    reqCode = CODE_NONE;
    if (reqFetch)                 reqCode = CODE_ISI;
    else if (reqUndef)            reqCode = CODE_ILL;
    else if (reqPriv)             reqCode = CODE_PRIV;
    else if (reqTrap)             reqCode = CODE_TRAP;
    else if (reqSc)               reqCode = CODE_SC;
    else if (reqData)             reqCode = CODE_DSI;
    else if (reqExt && msrIn[15]) reqCode = CODE_EXT;
  end

  assign take = (state == IDLE) && (reqCode != CODE_NONE);

  always_comb begin
    srr1Data     = msrLat & ~SRR1_CLR;
    srr1Data[19] = (codeLat == CODE_ILL);
    srr1Data[18] = (codeLat == CODE_PRIV);
    srr1Data[17] = (codeLat == CODE_TRAP);
  end

  always_comb begin
    case (codeLat)
      CODE_ISI:                       vecOffset = 12'h400;
      CODE_ILL, CODE_PRIV, CODE_TRAP: vecOffset = 12'h700;
      CODE_SC:                        vecOffset = 12'hC00;
      CODE_DSI:                       vecOffset = 12'h300;
      CODE_EXT:                       vecOffset = 12'h500;
      default:                        vecOffset = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      codeLat <= CODE_NONE;
      pcLat   <= '0;
      msrLat  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (take) begin
        codeLat <= reqCode;
        pcLat   <= excepPC;
        msrLat  <= msrIn;
      end
    end
  end

  // Outputs are a pure decode of state so an async reset zeroes them immediately.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    flush      = 1'b0;
    stall      = 1'b0;
    busy       = 1'b0;
    sprWrEn    = 1'b0;
    sprWrSel   = 2'd0;
    sprWrData  = 32'd0;
    pcRedirect = 1'b0;
    pcVector   = '0;
    excepCode  = CODE_NONE;
    case (state)
      IDLE: begin
        if (take) begin
          stateNext = FLUSH;
          cntNext   = 3'd0;
        end
`ifdef TOY_EXCEP_RFI_EN
        else if (rfiReq) begin
          stateNext = RFI_MSR;
        end
`endif
      end
      FLUSH: begin
        flush = 1'b1;
        stall = 1'b1;
        busy  = 1'b1;
        if (cnt == FLUSH_LAST) stateNext = SRR0;
        else                   cntNext   = cnt + 3'd1;
      end
      SRR0: begin
        stall     = 1'b1;
        busy      = 1'b1;
        sprWrEn   = 1'b1;
        sprWrSel  = SEL_SRR0;
        sprWrData = 32'(pcLat);
        stateNext = SRR1;
      end
      SRR1: begin
        stall     = 1'b1;
        busy      = 1'b1;
        sprWrEn   = 1'b1;
        sprWrSel  = SEL_SRR1;
        sprWrData = srr1Data;
        stateNext = MSR_WR;
      end
      MSR_WR: begin
        stall     = 1'b1;
        busy      = 1'b1;
        sprWrEn   = 1'b1;
        sprWrSel  = SEL_MSR;
        sprWrData = msrLat & ~MSR_CLR;
        stateNext = REDIR;
      end
      REDIR: begin
        stall      = 1'b1;
        busy       = 1'b1;
        pcRedirect = 1'b1;
        pcVector   = VEC_BASE | ADDR_WIDTH'(vecOffset);
        stateNext  = WAIT_ACK;
      end
      WAIT_ACK: begin
        stall     = 1'b1;
        busy      = 1'b1;
        excepCode = codeLat;
        if (ackIn) stateNext = IDLE;
      end
`ifdef TOY_EXCEP_RFI_EN
      RFI_MSR: begin
        flush     = 1'b1;
        stall     = 1'b1;
        busy      = 1'b1;
        sprWrEn   = 1'b1;
        sprWrSel  = SEL_MSR;
        sprWrData = srr1In;
        stateNext = RFI_REDIR;
      end
      RFI_REDIR: begin
        stall      = 1'b1;
        busy       = 1'b1;
        pcRedirect = 1'b1;
        pcVector   = srr0In;
        stateNext  = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_toy_excep_seq.sv
// Self-checking bench for toy_excep_seq: directed scenarios plus randomized exceptions against a reference model.
module tb_toy_excep_seq;
  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reqFetch = 0, reqUndef = 0, reqPriv = 0, reqTrap = 0;
  logic          reqSc = 0, reqData = 0, reqExt = 0;
  logic [AW-1:0] excepPC = '0;
  logic [31:0]   msrIn = '0;
  logic          ackIn = 1'b0;
  logic          flush, stall, sprWrEn, pcRedirect, busy;
  logic [1:0]    sprWrSel;
  logic [31:0]   sprWrData;
  logic [AW-1:0] pcVector;
  logic [3:0]    excepCode;
`ifdef TOY_EXCEP_RFI_EN
  logic          rfiReq = 1'b0;
  logic [AW-1:0] srr0In = '0;
  logic [31:0]   srr1In = '0;
`endif

  int checks = 0;
  int failures = 0;
  int txn = 0;

  always #5 clk = ~clk;

  toy_excep_seq #(.ADDR_WIDTH(AW), .VEC_BASE(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .reqFetch(reqFetch), .reqUndef(reqUndef), .reqPriv(reqPriv), .reqTrap(reqTrap),
    .reqSc(reqSc), .reqData(reqData), .reqExt(reqExt),
    .excepPC(excepPC), .msrIn(msrIn),
    .flush(flush), .stall(stall), .sprWrEn(sprWrEn), .sprWrSel(sprWrSel),
    .sprWrData(sprWrData), .pcRedirect(pcRedirect), .pcVector(pcVector),
    .excepCode(excepCode), .ackIn(ackIn), .busy(busy)
`ifdef TOY_EXCEP_RFI_EN
    , .rfiReq(rfiReq), .srr0In(srr0In), .srr1In(srr1In)
`endif
  );

  logic [74:0] allOut;
  assign allOut = {flush, stall, sprWrEn, sprWrSel, sprWrData, pcRedirect, pcVector, excepCode, busy};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: r bit order {ext,data,sc,trap,priv,undef,fetch}, code = bit index + 1.
  function automatic logic [3:0] refCode(input logic [6:0] r, input logic [31:0] msr);
    for (int i = 0; i < 7; i++)
      if (r[i] && (i != 6 || msr[15])) return 4'(i + 1);
    return 4'd0;
  endfunction

  function automatic logic [31:0] refSrr1(input logic [3:0] code, input logic [31:0] msr);
    logic [31:0] v;
    v = msr & ~(32'hF << 16);
    if (code >= 2 && code <= 4) v = v | (32'h1 << (21 - code));
    return v;
  endfunction

  function automatic logic [31:0] refMsr(input logic [31:0] msr);
    return msr & ~((32'h1 << 15) | (32'h1 << 14) | (32'h1 << 5) | (32'h1 << 4));
  endfunction

  function automatic logic [31:0] refVec(input logic [3:0] code);
    int offs [8] = '{0, 'h400, 'h700, 'h700, 'h700, 'hC00, 'h300, 'h500};
    return 32'(offs[code]);
  endfunction

  task automatic driveReqs(input logic [6:0] r);
    {reqExt, reqData, reqSc, reqTrap, reqPriv, reqUndef, reqFetch} = r;
  endtask

  task automatic doAck(input string name);
    ackIn = 1'b1;
    @(posedge clk); #1;
    ackIn = 1'b0;
    @(negedge clk);
    chk({name, "_idle_after_ack"}, {busy, excepCode, stall, flush}, 0);
  endtask

  task automatic runExc(input string name, input logic [6:0] r, input logic [31:0] pc,
                        input logic [31:0] msr, input bit hold, input bit injSc,
                        input bit earlyAck, input int ackDelay, input bit noAck);
    logic [3:0]  code;
    logic [33:0] wr [3];
    int          wrCyc [3];
    int          cyc, flushBad, stallBad, wrCount, redirCount, redirCyc, holdBad, idleBusy;
    logic [31:0] vec;
    bit          done;
    code = refCode(r, msr);
    cyc = 0; flushBad = 0; stallBad = 0; wrCount = 0; redirCount = 0; redirCyc = -1;
    holdBad = 0; idleBusy = 0; vec = '0; done = 0;
    for (int i = 0; i < 3; i++) begin wr[i] = '0; wrCyc[i] = -1; end
    @(negedge clk);
    driveReqs(r); excepPC = pc; msrIn = msr;
    @(posedge clk); #1;
    if (!hold) driveReqs(7'd0);
    if (code == 4'd0) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        idleBusy += int'(busy) + int'(stall) + int'(excepCode != 0);
      end
      chk({name, "_stays_idle"}, idleBusy, 0);
      $display("txn %0d %s reqs=%b msr=%h -> no exception", txn++, name, r, msr);
      return;
    end
    while (!done && cyc < 40) begin
      cyc++;
      if (injSc) reqSc = (cyc == 1);
      ackIn = earlyAck && (cyc <= FC + 4);
      @(negedge clk);
      if (excepCode != 4'd0) done = 1;
      else begin
        flushBad += int'(flush != (cyc <= FC));
        stallBad += int'(!stall || !busy);
        if (sprWrEn) begin
          if (wrCount < 3) begin wr[wrCount] = {sprWrSel, sprWrData}; wrCyc[wrCount] = cyc; end
          wrCount++;
        end
        if (pcRedirect) begin redirCount++; redirCyc = cyc; vec = pcVector; end
        @(posedge clk); #1;
      end
    end
    ackIn = 1'b0;
    chk({name, "_reached_wait_ack"}, done, 1);
    if (!done) return;
    chk({name, "_code"}, excepCode, code);
    chk({name, "_wait_cycle"}, cyc, FC + 5);
    chk({name, "_flush_pattern"}, flushBad, 0);
    chk({name, "_stall_busy"}, {stallBad, stall, busy}, {32'd0, 2'b11});
    chk({name, "_wr_count"}, wrCount, 3);
    chk({name, "_srr0"}, {wrCyc[0], wr[0]}, {FC + 1, 2'd0, pc});
    chk({name, "_srr1"}, {wrCyc[1], wr[1]}, {FC + 2, 2'd1, refSrr1(code, msr)});
    chk({name, "_msr"},  {wrCyc[2], wr[2]}, {FC + 3, 2'd2, refMsr(msr)});
    chk({name, "_redirect"}, {redirCount, redirCyc, vec}, {32'd1, FC + 4, refVec(code)});
    $display("txn %0d %s reqs=%b pc=%h msr=%h -> code=%0d vec=%h", txn++, name, r, pc, msr, excepCode, vec);
    if (noAck) return;
    for (int i = 0; i < ackDelay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      holdBad += int'(excepCode != code || !stall);
    end
    chk({name, "_code_held"}, holdBad, 0);
    doAck(name);
  endtask

  task automatic drainExc(input string name, input logic [3:0] expCode);
    int n;
    n = 0;
    while (excepCode == 4'd0 && n < 40) begin @(negedge clk); n++; end
    chk({name, "_code"}, excepCode, expCode);
    if (excepCode != 4'd0) doAck(name);
  endtask

  initial begin
    // Reset held with a request active: nothing may happen.
    reqFetch = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", allOut, 0);
    reqFetch = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("after_release_idle", allOut, 0);

    runExc("isi", 7'b0000001, 32'h100, 32'h8030, 0, 0, 0, 2, 0);
    runExc("prio_trap", 7'b0111000, 32'h2340, 32'h4000, 0, 0, 0, 0, 0);
    runExc("ext_masked", 7'b1000000, 32'h500, 32'h0000, 1, 0, 0, 0, 0);
    runExc("ext_enabled", 7'b1000000, 32'h504, 32'h8000, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("held_ext_retaken", busy, 1);
    driveReqs(7'd0);
    drainExc("ext_retake", 4'd7);
    runExc("dsi_busy_drop", 7'b0100000, 32'h880, 32'h8010, 0, 1, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("dropped_sc_not_taken", busy, 0);

    // Async reset in the middle of WAIT_ACK.
    runExc("pre_reset", 7'b0000010, 32'hABC0, 32'h0000FFFF, 0, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1 chk("reset_mid_wait_ack", allOut, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_release", allOut, 0);

    for (int k = 0; k < 25; k++) begin
      logic [6:0] r;
      r = 7'($urandom_range(0, 127));
      runExc($sformatf("rand%0d", k), r, $urandom, $urandom, 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

`ifdef TOY_EXCEP_RFI_EN
    @(negedge clk);
    rfiReq = 1'b1; srr0In = 32'h2000; srr1In = 32'h8000;
    @(posedge clk); #1;
    rfiReq = 1'b0;
    @(negedge clk);
    chk("rfi_msr", {flush, stall, busy, sprWrEn, sprWrSel, sprWrData, excepCode}, {4'b1111, 2'd2, 32'h8000, 4'd0});
    @(negedge clk);
    chk("rfi_redir", {flush, stall, pcRedirect, pcVector, sprWrEn, excepCode}, {3'b011, 32'h2000, 1'b0, 4'd0});
    @(negedge clk);
    chk("rfi_done", allOut, 0);
    $display("txn %0d rfi srr0=%h srr1=%h", txn++, srr0In, srr1In);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/toy_excep_seq.md
Name: toy_excep_seq

Overview:
- Exception sequencer for the in-order PPC core.
- Takes per-stage exception flags (the registered isFetch/isUndefined/isPriveleged/isTraped/sc/isLoad/isStore set plus external interrupt). Selects one by fixed priority, then runs a multi-cycle handling sequence:
  - flush and stall the pipeline;
  - write SRR0, SRR1 and MSR through the SPR write port;
  - redirect the PC to the vector;
  - present excepCode to the controller and wait for its ack.

Parameters:
- ADDR_WIDTH, 32: width of PC, SPR data and vector.
- VEC_BASE, 32'h0000_0000: base OR'd onto every vector offset.
- FLUSH_CYCLES, 2: number of cycles flush is held (1..7).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- reqFetch  in  1  ISI (instruction fetch fault).
- reqUndef  in  1  program exception, illegal instruction.
- reqPriv  in  1  program exception, privileged instruction.
- reqTrap  in  1  program exception, trap.
- reqSc  in  1  system call.
- reqData  in  1  DSI (load or store fault).
- reqExt  in  1  external interrupt, level-sensitive.
- excepPC  in  ADDR_WIDTH  address of the faulting instruction.
- msrIn  in  32  current MSR.
- flush  out  1  pipeline flush.
- stall  out  1  pipeline stall (freeze PC/IF).
- sprWrEn  out  1  SPR write strobe.
- sprWrSel  out  2  SPR select: 0=SRR0, 1=SRR1, 2=MSR.
- sprWrData  out  32  SPR write data.
- pcRedirect  out  1  load pcVector into PC.
- pcVector  out  ADDR_WIDTH  vector address.
- excepCode  out  4  0=NONE, 1=ISI, 2=ILL, 3=PRIV, 4=TRAP, 5=SC, 6=DSI, 7=EXT.
- ackIn  in  1  ack from the controller.
- busy  out  1  sequencer not in IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE;
  - all outputs 0, including excepCode=NONE and busy=0;
  - latches cleared.
  - Deassertion takes effect at the next posedge.
- Priority, high to low: Fetch, Undef, Priv, Trap, Sc, Data, Ext.
  - reqExt counts only when msrIn[15] (EE)=1.
  - Lower-priority requests in the same cycle are dropped, not queued.
- IDLE:
  - If any eligible request is present, latch code, excepPC and msrIn, then go to FLUSH.
  - Outputs are 0 in IDLE.
- FLUSH:
  - flush=1, stall=1, held for FLUSH_CYCLES cycles using a 3-bit counter; then go to SRR0.
- SRR0 (1 cycle): sprWrEn=1, sel=0, data=latched PC.
- SRR1 (1 cycle): sprWrEn=1, sel=1.
  - data = latched MSR with bits [19:16] cleared, then bit19=ILL, bit18=PRIV, bit17=TRAP according to the code.
- MSR (1 cycle): sprWrEn=1, sel=2.
  - data = latched MSR with bits 15 (EE), 14 (PR), 5 (IR) and 4 (DR) cleared.
- REDIR (1 cycle): pcRedirect=1.
  - pcVector = VEC_BASE | offset, where offset is: ISI 0x400, ILL/PRIV/TRAP 0x700, SC 0xC00, DSI 0x300, EXT 0x500.
- WAIT_ACK:
  - excepCode = latched code; stall=1.
  - If ackIn=1, go to IDLE next cycle and drop excepCode to NONE.
- excepCode is NONE in every state other than WAIT_ACK.
- stall=1 in every state except IDLE.
- busy=1 in every state except IDLE.
- Requests are ignored whenever busy=1.
- A request level still high on return to IDLE is taken as a new exception.
- Minimum latency, request to pcRedirect: FLUSH_CYCLES+4 cycles (request sampled at edge 0, redirect during cycle FLUSH_CYCLES+4).
- ackIn asserted outside WAIT_ACK is ignored.
- Reset asserted mid-sequence aborts immediately; no partial SPR write completes after reset.

Optional Feature:
- Macro: TOY_EXCEP_RFI_EN.
- With the macro, extra ports are present: rfiReq in 1, srr0In in ADDR_WIDTH, srr1In in 32.
  - In IDLE with no eligible exception, rfiReq=1 starts the RFI sequence: RFI_MSR (sprWrEn=1, sel=2, data=srr1In) then RFI_REDIR (pcRedirect=1, pcVector=srr0In), then IDLE.
  - stall=1 during both states; flush=1 during RFI_MSR.
  - excepCode stays NONE; no ack is required.
  - An exception in the same cycle wins over rfiReq.
- Without the macro: the extra ports and the RFI states are absent.

Test Plan:
- Reset: rst=0 mid-WAIT_ACK → all outputs 0 the same cycle; idle after release.
- Single ISI: reqFetch=1, excepPC=0x100, msrIn=0x8030, FLUSH_CYCLES=2:
  - flush for 2 cycles;
  - SRR0 write 0x100; SRR1 write 0x8030; MSR write 0x0000;
  - pcRedirect with vector 0x400;
  - excepCode=1 until ackIn.
- Priority: reqTrap, reqSc and reqData all at once, msrIn=0x4000:
  - code=4 (TRAP);
  - SRR1 data=0x24000;
  - vector 0x700.
- External masking:
  - reqExt=1, msrIn=0x0000 → stays IDLE indefinitely.
  - Then msrIn=0x8000 → code=7, vector 0x500, MSR write 0x0000.
- Busy drop: reqSc pulsed during FLUSH of a DSI → only DSI handled (vector 0x300); a held request is retaken after ack.
- RFI (macro on): rfiReq=1, srr0In=0x2000, srr1In=0x8000 → MSR write 0x8000, then pcRedirect to 0x2000, excepCode stays 0.
